// File: rtl/serial_word_packer.sv
// Packs an LSB-first serial bit stream into WIDTH-bit words with even parity.
// Words leave through a ready/valid port. A word completed while the port is stalled is dropped and flagged.
module serial_word_packer #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_parity,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_parity_q, word_parity_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             complete;
  logic             can_load;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] full_word;

  assign accept    = ser_valid && !clear;
  assign complete  = accept && (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign can_load  = !word_valid_q || word_ready;
  assign bit_mask  = WIDTH'(1) << bit_cnt_q;
  // The completed word includes the bit arriving on this edge.
  assign full_word = (acc_q & ~bit_mask) | (ser_in ? bit_mask : '0);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    word_out_d    = word_out_q;
    word_parity_d = word_parity_q;
    word_valid_d  = word_valid_q;
    overflow_d    = overflow_q;

    if (clear) begin
      acc_d         = '0;
      bit_cnt_d     = '0;
      word_out_d    = '0;
      word_parity_d = 1'b0;
      word_valid_d  = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      if (word_valid_q && word_ready) begin
        word_valid_d = 1'b0;
      end

      if (complete) begin
        // Zero the accumulator on wrap so stale bits never leak into the next word.
        acc_d     = '0;
        bit_cnt_d = '0;
        if (can_load) begin
          word_out_d    = full_word;
          word_parity_d = PARITY_EN && (^full_word);
          word_valid_d  = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (accept) begin
        acc_d     = full_word;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      word_out_q    <= '0;
      word_parity_q <= 1'b0;
      word_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      word_out_q    <= word_out_d;
      word_parity_q <= word_parity_d;
      word_valid_q  <= word_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign word_out    = word_out_q;
  assign word_parity = word_parity_q;
  assign word_valid  = word_valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
Downstream consumer of the LFSR serial output stream (OUT/valid). It accepts one serial bit per clock while the input valid is high and packs the bits LSB-first into WIDTH-bit words. Each completed word is presented with an even-parity bit on a ready/valid output interface. The serial source has no backpressure, so a completed word that cannot be delivered is dropped and flagged.

Parameters:
WIDTH, 8, bits per packed word (range 2 to 32)
PARITY_EN, 1, 1 = word_parity carries the XOR of word_out; 0 = word_parity tied 0

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
ser_in  input  1  serial data bit (driven by LFSR OUT)
ser_valid  input  1  ser_in is valid this cycle (driven by LFSR valid)
clear  input  1  synchronous flush of the accumulator, output and flags
word_out  output  WIDTH  packed word, first-received bit in bit 0
word_parity  output  1  even parity of word_out
word_valid  output  1  word_out/word_parity hold an undelivered word
word_ready  input  1  consumer accepts the word this cycle when word_valid=1
bit_cnt  output  clog2(WIDTH+1)  bits accumulated in the current partial word
overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Reset: RST low asynchronously clears accumulator, bit_cnt, word_out, word_parity, word_valid and overflow to 0.
- State: COLLECT only; bit_cnt runs 0..WIDTH-1 and wraps.
- Accept rule: on a rising edge with ser_valid=1 and clear=0, ser_in goes into accumulator bit [bit_cnt] and bit_cnt increments.
- ser_valid=0: accumulator and bit_cnt hold. Gaps of any length are allowed.
- Word completion happens when a bit is accepted with bit_cnt=WIDTH-1:
  - The full word, including the bit just accepted, is the completed word.
  - bit_cnt returns to 0 on that edge.
- Output load: the completed word is loaded into word_out on the same edge if either word_valid=0, or word_valid=1 and word_ready=1. word_valid is then 1 from the next cycle.
  - Latency: last bit sampled at edge N gives word_valid=1 after edge N.
- Handshake:
  - A transfer occurs when word_valid=1 and word_ready=1 at a rising edge.
  - word_valid drops after the edge unless a new word loads on the same edge. In that case word_valid stays 1 and word_out updates with no bubble.
  - word_out and word_parity are stable while word_valid=1 and word_ready=0.
- Overflow: a word completes while word_valid=1 and word_ready=0:
  - The new word is discarded and overflow is set (sticky).
  - word_out keeps the old word.
  - Accumulation continues normally.
- Parity: word_parity is the XOR reduction of the loaded word when PARITY_EN=1. It is registered alongside word_out.
- clear=1:
  - Takes priority over ser_valid and word_ready.
  - Next cycle: bit_cnt=0, accumulator=0, word_valid=0, overflow=0. word_out and word_parity are zeroed.
  - A bit presented in the same cycle is dropped.
- Reset mid-word: any partial word is lost, and the next accepted bit lands in bit 0.
- word_ready is ignored while word_valid=0.

Test Plan:
1. WIDTH=8, word_ready=1, serial bits 1,0,1,1,0,0,1,0 with ser_valid=1 on consecutive cycles -> one cycle after the 8th bit, word_valid=1, word_out=0x4D, word_parity=0, bit_cnt=0.
2. Same 8 bits with ser_valid=0 gaps of 3 cycles between bits -> same result (0x4D, parity 0). bit_cnt holds during gaps and reads 1..7 between bits.
3. Back-to-back stream of 0x4D then 0xFF bits (LSB-first), word_ready=1 -> word_valid stays high continuously across the word boundary. word_out goes 0x4D then 0xFF with parity 0 then 0. overflow=0.
4. word_ready=0, 16 bits forming 0x12 then 0x34 -> word_out stays 0x12 and overflow=1 after the 16th bit. Raising word_ready completes the transfer and word_valid drops. overflow remains 1 until clear.
5. Five bits accepted, then RST pulsed low for 1 cycle -> all outputs read 0 immediately. Next bits 1,1,1,1,1,1,1,1 -> word_out=0xFF, parity 0.
6. clear=1 asserted on the same cycle as the 8th bit with ser_valid=1 -> no word is produced, word_valid=0, bit_cnt=0, overflow=0.
